// File: rtl/nand_gate_unit.sv
`default_nettype none
// ============================================================================
// Module   : nand_gate_unit
// Purpose  : Bit-wise 2-input NAND with a combinational result, a 1-cycle
//            registered copy plus valid flag, and saturating truth-table
//            coverage counters for lane 0.
// Ports    :
//   clk        in   1      system clock, rising-edge
//   rst        in   1      synchronous reset, active-high
//   A, B       in   WIDTH  operands
//   in_valid   in   1      qualifies A/B for the registered path and counters
//   clear      in   1      synchronous clear of the coverage counters only
//   O          out  WIDTH  combinational ~(A & B)
//   O_reg      out  WIDTH  registered ~(A & B), captured when in_valid=1
//   out_valid  out  1      O_reg holds a fresh result this cycle
//   cnt00..11  out  CNT_W  accepted samples per {A[0],B[0]} combination
//   cov_done   out  1      all four counters nonzero
// Revision : 1.0 - initial release
// ============================================================================
module nand_gate_unit #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             in_valid,
  input  logic             clear,
  output logic [WIDTH-1:0] O,
  output logic [WIDTH-1:0] O_reg,
  output logic             out_valid,
  output logic [CNT_W-1:0] cnt00,
  output logic [CNT_W-1:0] cnt01,
  output logic [CNT_W-1:0] cnt10,
  output logic [CNT_W-1:0] cnt11,
  output logic             cov_done
);

  localparam logic [CNT_W-1:0] C_CNT_MAX = '1;

  logic [WIDTH-1:0] o_reg_q, o_reg_d;
  logic             out_valid_q, out_valid_d;
  logic [CNT_W-1:0] cnt_q [4];
  logic [CNT_W-1:0] cnt_d [4];
  logic [1:0]       w_sel;

  // Combinational result; X/Z on inputs propagates naturally.
  assign O     = ~(A & B);
  assign w_sel = {A[0], B[0]};

  always_comb begin
    o_reg_d     = o_reg_q;
    out_valid_d = in_valid;
    for (int i = 0; i < 4; i++) begin
      cnt_d[i] = cnt_q[i];
    end

    if (in_valid) begin
      o_reg_d = ~(A & B);
    end

    // Clear beats counting; the registered data path is unaffected by clear.
    if (clear) begin
      for (int i = 0; i < 4; i++) begin
        cnt_d[i] = '0;
      end
    end else if (in_valid && (cnt_q[w_sel] != C_CNT_MAX)) begin
      cnt_d[w_sel] = cnt_q[w_sel] + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      o_reg_q     <= '1;
      out_valid_q <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      o_reg_q     <= o_reg_d;
      out_valid_q <= out_valid_d;
      for (int i = 0; i < 4; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign O_reg     = o_reg_q;
  assign out_valid = out_valid_q;
  assign cnt00     = cnt_q[0];
  assign cnt01     = cnt_q[1];
  assign cnt10     = cnt_q[2];
  assign cnt11     = cnt_q[3];
  assign cov_done  = (cnt_q[0] != '0) && (cnt_q[1] != '0) &&
                     (cnt_q[2] != '0) && (cnt_q[3] != '0);

endmodule
`default_nettype wire

// File: tb/tb_nand_gate_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_nand_gate_unit
// Purpose  : Self-checking bench for nand_gate_unit (WIDTH=4, CNT_W=2).
// Revision : 1.0 - initial release
// ============================================================================
module tb_nand_gate_unit;

  localparam int WIDTH = 4;
  localparam int CNT_W = 2;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] A, B;
  logic             in_valid, clear;
  logic [WIDTH-1:0] O, O_reg;
  logic             out_valid;
  logic [CNT_W-1:0] cnt00, cnt01, cnt10, cnt11;
  logic             cov_done;

  nand_gate_unit #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .A(A), .B(B), .in_valid(in_valid), .clear(clear),
    .O(O), .O_reg(O_reg), .out_valid(out_valid),
    .cnt00(cnt00), .cnt01(cnt01), .cnt10(cnt10), .cnt11(cnt11),
    .cov_done(cov_done)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference state
  int m_oreg;
  int m_ovalid;
  int m_cnt [4];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs just after an edge, check O, step the model at
  // the edge, then check every registered output 1 ns later.
  task automatic step(input int a, input int b, input int v, input int c, input int r);
    int idx;
    int nand_v;
    A = a[WIDTH-1:0]; B = b[WIDTH-1:0];
    in_valid = v[0]; clear = c[0]; rst = r[0];
    nand_v = (~(a & b)) & ((1 << WIDTH) - 1);
    #1;
    chk("O", 32'(O), 32'(nand_v));
    @(posedge clk);
    if (r != 0) begin
      m_oreg = (1 << WIDTH) - 1;
      m_ovalid = 0;
      for (int i = 0; i < 4; i++) m_cnt[i] = 0;
    end else begin
      m_ovalid = v;
      if (v != 0) m_oreg = nand_v;
      if (c != 0) begin
        for (int i = 0; i < 4; i++) m_cnt[i] = 0;
      end else if (v != 0) begin
        idx = (a & 1) * 2 + (b & 1);
        if (m_cnt[idx] < CMAX) m_cnt[idx] = m_cnt[idx] + 1;
      end
    end
    #1;
    chk("O_reg", 32'(O_reg), 32'(m_oreg));
    chk("out_valid", 32'(out_valid), 32'(m_ovalid));
    chk("cnt00", 32'(cnt00), 32'(m_cnt[0]));
    chk("cnt01", 32'(cnt01), 32'(m_cnt[1]));
    chk("cnt10", 32'(cnt10), 32'(m_cnt[2]));
    chk("cnt11", 32'(cnt11), 32'(m_cnt[3]));
    chk("cov_done", 32'(cov_done),
        32'((m_cnt[0] > 0 && m_cnt[1] > 0 && m_cnt[2] > 0 && m_cnt[3] > 0) ? 1 : 0));
  endtask

  initial begin
    int a, b, v, c, r;
    m_oreg = 0; m_ovalid = 0;
    for (int i = 0; i < 4; i++) m_cnt[i] = 0;
    A = '0; B = '0; in_valid = 1'b0; clear = 1'b0; rst = 1'b1;
    @(posedge clk);

    // Reset held 2 edges while a valid AB=11 sample is presented.
    step(4'hF, 4'hF, 1, 0, 1);
    step(4'hF, 4'hF, 1, 0, 1);
    chk("rst_oreg_const", 32'(O_reg), 32'hF);
    chk("rst_cov_const", 32'(cov_done), 32'h0);

    // Truth table on lane 0: AB = 00, 10, 11, 01; cov_done only after the 4th.
    step(0, 0, 1, 0, 0);
    step(1, 0, 1, 0, 0);
    step(1, 1, 1, 0, 0);
    chk("cov_before_4th", 32'(cov_done), 32'h0);
    step(0, 1, 1, 0, 0);
    chk("cov_after_4th", 32'(cov_done), 32'h1);

    // Clear with a valid AB=11 sample: counters 0, data path still updates.
    step(4'hF, 4'hF, 1, 1, 0);
    chk("clr_oreg", 32'(O_reg), 32'h0);
    chk("clr_valid", 32'(out_valid), 32'h1);

    // Saturation: 5 samples of AB=00 -> 1,2,3,3,3.
    for (int k = 0; k < 5; k++) step(0, 0, 1, 0, 0);
    chk("sat_cnt00", 32'(cnt00), 32'h3);

    // Multi-lane pattern, then idle cycle holds O_reg.
    step(4'b1100, 4'b1010, 1, 0, 0);
    chk("w4_oreg", 32'(O_reg), 32'b0111);
    step(4'b1111, 4'b1111, 0, 0, 0);
    chk("w4_hold", 32'(O_reg), 32'b0111);
    chk("w4_novalid", 32'(out_valid), 32'h0);

    // Randomized traffic with occasional clear and reset.
    for (int k = 0; k < 400; k++) begin
      a = int'($urandom_range(0, 15));
      b = int'($urandom_range(0, 15));
      v = ($urandom_range(0, 3) != 0) ? 1 : 0;
      c = ($urandom_range(0, 19) == 0) ? 1 : 0;
      r = ($urandom_range(0, 39) == 0) ? 1 : 0;
      step(a, b, v, c, r);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
